// File: rtl/byte_unstriping_4_if.sv
// Byte stream in, four-lane word out, with valid/ready on both sides.
interface byte_unstriping_4_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dataIn;
  logic              validIn;
  logic              inReady;
  logic [DATA_W-1:0] dataOut0;
  logic [DATA_W-1:0] dataOut1;
  logic [DATA_W-1:0] dataOut2;
  logic [DATA_W-1:0] dataOut3;
  logic              validOut0;
  logic              validOut1;
  logic              validOut2;
  logic              validOut3;
  logic              outReady;

  modport master (
    output dataIn, validIn, outReady,
    input  inReady, dataOut0, dataOut1, dataOut2, dataOut3,
    input  validOut0, validOut1, validOut2, validOut3
  );

  modport slave (
    input  dataIn, validIn, outReady,
    output inReady, dataOut0, dataOut1, dataOut2, dataOut3,
    output validOut0, validOut1, validOut2, validOut3
  );
endinterface

// File: rtl/byte_unstriping_4.sv
// Gathers a byte stream into 4-lane words (lane 0 first); idle partial words are flushed.
// Word appears one cycle after its last byte; the output word is held while outReady=0.
module byte_unstriping_4 #(
  parameter int DATA_W     = 8,
  parameter int IDLE_FLUSH = 4
) (
  input  logic                clk,
  input  logic                reset,
  byte_unstriping_4_if.slave  bus
);
  localparam int CW = (IDLE_FLUSH < 1) ? 1 : $clog2(IDLE_FLUSH + 1);

  typedef enum logic [1:0] {S_EMPTY, S_FILL, S_FLUSH_WAIT} state_t;

  state_t            r_state;
  logic [1:0]        r_ptr;
  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_stage [3];
  logic [DATA_W-1:0] r_dout  [4];
  logic [3:0]        r_vout;

  logic       w_out_full;
  logic       w_free;
  logic       w_in_ready;
  logic       w_accept;
  logic       w_complete;
  logic       w_cnt_hit;
  logic       w_flush;
  logic [3:0] w_flush_mask;

  assign w_out_full = |r_vout;
  assign w_free     = !w_out_full || bus.outReady;
  // Only the word-completing byte needs the output slot, so only lane 3 can stall.
  assign w_in_ready = !((r_ptr == 2'd3) && w_out_full && !bus.outReady);
  assign w_accept   = bus.validIn && w_in_ready;
  assign w_complete = w_accept && (r_ptr == 2'd3);
  assign w_cnt_hit  = (IDLE_FLUSH != 0) && (r_cnt == CW'(IDLE_FLUSH));
  assign w_flush    = (r_ptr != 2'd0) && !bus.validIn && w_free &&
                      (w_cnt_hit || (r_state == S_FLUSH_WAIT));

  always_comb begin
    w_flush_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_flush_mask[i] = (i < int'(r_ptr));
    end
  end

  assign bus.inReady   = w_in_ready;
  assign bus.dataOut0  = r_dout[0];
  assign bus.dataOut1  = r_dout[1];
  assign bus.dataOut2  = r_dout[2];
  assign bus.dataOut3  = r_dout[3];
  assign bus.validOut0 = r_vout[0];
  assign bus.validOut1 = r_vout[1];
  assign bus.validOut2 = r_vout[2];
  assign bus.validOut3 = r_vout[3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_vout  <= 4'b0000;
      for (int i = 0; i < 3; i++) r_stage[i] <= '0;
      for (int i = 0; i < 4; i++) r_dout[i]  <= '0;
    end else begin
      // Output register: a new load wins over clearing a consumed word.
      if (w_complete) begin
        for (int i = 0; i < 3; i++) r_dout[i] <= r_stage[i];
        r_dout[3] <= bus.dataIn;
        r_vout    <= 4'b1111;
      end else if (w_flush) begin
        for (int i = 0; i < 3; i++) r_dout[i] <= w_flush_mask[i] ? r_stage[i] : '0;
        r_dout[3] <= '0;
        r_vout    <= w_flush_mask;
      end else if (w_out_full && bus.outReady) begin
        for (int i = 0; i < 4; i++) r_dout[i] <= '0;
        r_vout <= 4'b0000;
      end

      if (w_complete || w_flush) begin
        r_ptr <= 2'd0;
        r_cnt <= '0;
        for (int i = 0; i < 3; i++) r_stage[i] <= '0;
      end else if (w_accept) begin
        r_stage[r_ptr] <= bus.dataIn;
        r_ptr          <= r_ptr + 2'd1;
        r_cnt          <= '0;
      end else if ((IDLE_FLUSH != 0) && (r_ptr != 2'd0) && !bus.validIn && !w_cnt_hit) begin
        r_cnt <= r_cnt + CW'(1);
      end

      case (r_state)
        S_EMPTY: begin
          if (w_accept) r_state <= S_FILL;
        end
        S_FILL, S_FLUSH_WAIT: begin
          if (w_complete || w_flush)                         r_state <= S_EMPTY;
          else if (w_accept)                                 r_state <= S_FILL;
          else if (w_cnt_hit && !w_free && !bus.validIn)     r_state <= S_FLUSH_WAIT;
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_byte_unstriping_4.sv
// Scoreboard bench for byte_unstriping_4: queue-based word model, directed scenarios then random traffic.
module tb_byte_unstriping_4;
  localparam int DW = 8;
  localparam int IF = 4;

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [3:0]      v;
  } word_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  byte_unstriping_4_if #(.DATA_W(DW)) bus ();

  byte_unstriping_4 #(.DATA_W(DW), .IDLE_FLUSH(IF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  word_t      exp_q[$];
  logic [7:0] m_bytes[$];
  int         m_idle = 0;
  bit         m_full = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] dut_vout();
    return {bus.validOut3, bus.validOut2, bus.validOut1, bus.validOut0};
  endfunction

  function automatic logic [31:0] dut_dout();
    return {bus.dataOut3, bus.dataOut2, bus.dataOut1, bus.dataOut0};
  endfunction

  function automatic word_t pack_word();
    word_t w;
    w = '0;
    foreach (m_bytes[i]) begin
      w.d[i] = m_bytes[i];
      w.v[i] = 1'b1;
    end
    return w;
  endfunction

  // Reference model: evaluated mid-cycle with the inputs that the next posedge will see.
  always @(negedge clk) begin
    bit ready, free, consume, load;
    if (reset) begin
      check("reset_inReady", 64'(bus.inReady), 64'd1);
      check("reset_validOut", 64'(dut_vout()), 64'd0);
      check("reset_dataOut", 64'(dut_dout()), 64'd0);
      m_bytes.delete();
      exp_q.delete();
      m_idle = 0;
      m_full = 1'b0;
    end else begin
      ready   = !(m_bytes.size() == 3 && m_full && !bus.outReady);
      free    = !m_full || bus.outReady;
      consume = m_full && bus.outReady;
      load    = 1'b0;
      check("inReady", 64'(bus.inReady), 64'(ready));
      check("outFull", 64'(|dut_vout()), 64'(m_full));
      if (bus.validIn && ready) begin
        m_bytes.push_back(bus.dataIn);
        m_idle = 0;
        if (m_bytes.size() == 4) begin
          exp_q.push_back(pack_word());
          m_bytes.delete();
          load = 1'b1;
        end
      end else if (!bus.validIn && m_bytes.size() > 0) begin
        if (IF > 0 && m_idle >= IF && free) begin
          exp_q.push_back(pack_word());
          m_bytes.delete();
          m_idle = 0;
          load = 1'b1;
        end else if (m_idle < IF) begin
          m_idle++;
        end
      end
      if (load)         m_full = 1'b1;
      else if (consume) m_full = 1'b0;
    end
  end

  // Monitor: compares each word the consumer actually takes.
  always @(negedge clk) begin
    word_t w;
    if (!reset) begin
      if (|dut_vout()) begin
        if (bus.outReady) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word actual=%h/%b required=none", dut_dout(), dut_vout());
          end else begin
            w = exp_q.pop_front();
            check("word_data", 64'(dut_dout()), 64'(w.d));
            check("word_valid", 64'(dut_vout()), 64'(w.v));
          end
        end
      end else begin
        check("idle_data_zero", 64'(dut_dout()), 64'd0);
      end
    end
  end

  task automatic tick(input logic v, input logic [7:0] d, input logic r, output logic acc);
    bus.validIn  = v;
    bus.dataIn   = d;
    bus.outReady = r;
    #3;
    acc = v & bus.inReady;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic r);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      tick(1'b1, d, r, acc);
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout actual=not_accepted required=accepted byte=%h", d);
    end
  endtask

  task automatic idle(input int n, input logic r);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, r, acc);
  endtask

  task automatic pulse_reset();
    bus.validIn = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic       acc;
    logic       r;
    logic [7:0] pend;
    bit         have;
    int         gap;

    reset        = 1'b1;
    bus.validIn  = 1'b0;
    bus.dataIn   = 8'h00;
    bus.outReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single word, full throughput.
    send(8'hFF, 1'b1); send(8'hEE, 1'b1); send(8'hDD, 1'b1); send(8'hCC, 1'b1);
    idle(3, 1'b1);

    // Two back-to-back words.
    send(8'hBB, 1'b1); send(8'hAA, 1'b1); send(8'h99, 1'b1); send(8'h88, 1'b1);
    send(8'h77, 1'b1); send(8'h66, 1'b1); send(8'h55, 1'b1); send(8'h44, 1'b1);
    idle(3, 1'b1);

    // One byte then idle: partial flush.
    send(8'h77, 1'b1);
    idle(8, 1'b1);

    // Held word, lane-3 stall, consume and load on the same edge.
    send(8'hFF, 1'b0); send(8'hEE, 1'b0); send(8'hDD, 1'b0); send(8'hCC, 1'b0);
    idle(1, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'h44, 1'b0, acc);
      check("lane3_stall", 64'(acc), 64'd0);
    end
    tick(1'b1, 8'h44, 1'b1, acc);
    check("lane3_release", 64'(acc), 64'd1);
    idle(3, 1'b1);

    // Reset mid-word discards staged bytes.
    send(8'hA1, 1'b1); send(8'hA2, 1'b1);
    pulse_reset();
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
    idle(3, 1'b1);

    // Flush deferred behind a held word.
    send(8'hFF, 1'b0); send(8'hEE, 1'b0); send(8'hDD, 1'b0); send(8'hCC, 1'b0);
    send(8'h55, 1'b0);
    idle(10, 1'b0);
    idle(4, 1'b1);

    // Random traffic with bursts, idle gaps and backpressure.
    have = 1'b0;
    gap  = 0;
    pend = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 3) != 0);
      if (!have && gap == 0) begin
        if ($urandom_range(0, 9) == 0) gap = $urandom_range(1, 8);
        else begin
          have = 1'b1;
          pend = 8'($urandom);
        end
      end
      if (have) begin
        tick(1'b1, pend, r, acc);
        if (acc) have = 1'b0;
      end else begin
        tick(1'b0, 8'h00, r, acc);
        gap--;
      end
    end

    idle(12, 1'b1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
